pc_fetch_unit: RTL and testbench

- Program-counter and fetch-control stage of the single-cycle CPU.
- Sits directly upstream of the instruction memory: drives its `pc` and `InsMemRW` inputs, and takes its `op` output back for halt detection.
- Computes the next PC from the sequential, branch and jump sources.
- Runs a small boot/run/halt state machine and counts retired instructions.

---
 rtl/pc_fetch_unit.sv | 120 ++++++++++++
 tb/tb_pc_fetch_unit.sv | 186 ++++++++++++++++++
 2 files changed

// File: rtl/pc_fetch_unit.sv
// pc_fetch_unit: program counter and fetch control for the single-cycle CPU.
// Computes the next PC, sequences BOOT/RUN/HALT, and counts retired
// instructions with a saturating counter.
//
// state | meaning
// BOOT  | one cycle after reset release; fetch disabled, pc held
// RUN   | fetching; pc advances when PCWre is set, halt opcode stops fetch
// HALT  | fetch disabled, pc frozen on the halt instruction until resume
module pc_fetch_unit #(
    parameter logic [31:0] RESET_PC = 32'h0000_0000,
    parameter int          CNT_W    = 32,
    parameter logic [5:0]  HALT_OP  = 6'b111111
) (
    input  logic             CLK,
    input  logic             Reset,
    input  logic             PCWre,
    input  logic [1:0]       PCSrc,
    input  logic             zero,
    input  logic [15:0]      immediate,
    input  logic [25:0]      jump_addr,
    input  logic [5:0]       op,
    input  logic             resume,
    output logic [31:0]      pc,
    output logic [31:0]      pc_plus4,
    output logic             InsMemRW,
    output logic             halted,
    output logic [CNT_W-1:0] retired
);

    typedef enum logic [1:0] {
        ST_BOOT = 2'd0,
        ST_RUN  = 2'd1,
        ST_HALT = 2'd2
    } state_t;

    state_t           r_state;
    logic [31:0]      r_pc;
    logic [CNT_W-1:0] r_retired;
    logic             r_insmem_rw;
    logic             r_halted;

    logic [31:0]      w_pc_plus4;
    logic [31:0]      w_branch_off;
    logic [31:0]      w_branch_tgt;
    logic [31:0]      w_jump_tgt;
    logic [31:0]      w_next_pc;
    logic             w_ret_sat;

    assign w_pc_plus4   = r_pc + 32'd4;
    // Word offset sign-extended and scaled to bytes; keeps pc word-aligned.
    assign w_branch_off = {{14{immediate[15]}}, immediate, 2'b00};
    assign w_branch_tgt = w_pc_plus4 + w_branch_off;
    assign w_jump_tgt   = {w_pc_plus4[31:28], jump_addr, 2'b00};
    assign w_ret_sat    = (r_retired == {CNT_W{1'b1}});

    // Next-PC source select; a not-taken branch falls through to pc + 4.
    always_comb begin
        w_next_pc = w_pc_plus4;
        case (PCSrc)
            2'b00:   w_next_pc = w_pc_plus4;
            2'b01:   w_next_pc = zero ? w_branch_tgt : w_pc_plus4;
            2'b10:   w_next_pc = w_jump_tgt;
            default: w_next_pc = r_pc;
        endcase
    end

    // Fetch FSM with registered Moore outputs, pc and retired counter.
    always_ff @(posedge CLK or negedge Reset) begin
        if (!Reset) begin
            r_state     <= ST_BOOT;
            r_pc        <= RESET_PC;
            r_retired   <= '0;
            r_insmem_rw <= 1'b0;
            r_halted    <= 1'b0;
        end else begin
            case (r_state)
                ST_BOOT: begin
                    r_state     <= ST_RUN;
                    r_insmem_rw <= 1'b1;
                    r_halted    <= 1'b0;
                end
                ST_RUN: begin
                    // Halt opcode wins over PCWre/PCSrc; the halt itself is not retired.
                    if (op == HALT_OP) begin
                        r_state     <= ST_HALT;
                        r_insmem_rw <= 1'b0;
                        r_halted    <= 1'b1;
                    end else if (PCWre) begin
                        r_pc <= w_next_pc;
                        if (!w_ret_sat) begin
                            r_retired <= r_retired + CNT_W'(1);
                        end
                    end
                end
                ST_HALT: begin
                    // op is not looked at here, so a lingering halt opcode
                    // is only acted on again from the first RUN cycle.
                    if (resume) begin
                        r_state     <= ST_RUN;
                        r_pc        <= w_pc_plus4;
                        r_insmem_rw <= 1'b1;
                        r_halted    <= 1'b0;
                    end
                end
                default: begin
                    r_state     <= ST_BOOT;
                    r_insmem_rw <= 1'b0;
                    r_halted    <= 1'b0;
                end
            endcase
        end
    end

    assign pc       = r_pc;
    assign pc_plus4 = w_pc_plus4;
    assign InsMemRW = r_insmem_rw;
    assign halted   = r_halted;
    assign retired  = r_retired;

endmodule

// File: tb/tb_pc_fetch_unit.sv
// tb_pc_fetch_unit: table-driven directed checks of pc_fetch_unit, plus
// hand-written reset sequences. A second instance with a high RESET_PC and
// a 4-bit counter covers upper-nibble jumps, address wrap and saturation.
module tb_pc_fetch_unit;

    typedef struct {
        logic        pcwre;
        logic [1:0]  pcsrc;
        logic        zero;
        logic [15:0] imm;
        logic [25:0] jaddr;
        logic [5:0]  op;
        logic        resume;
        logic [31:0] e_pc;
        logic [31:0] e_ret;
        logic        e_halt;
        logic        e_rw;
    } vec_t;

    logic        clk;
    logic        rst_n;
    logic        rst2_n;
    logic        PCWre;
    logic [1:0]  PCSrc;
    logic        zero;
    logic [15:0] immediate;
    logic [25:0] jump_addr;
    logic [5:0]  op;
    logic        resume;

    logic [31:0] pc1, pc1_p4, ret1;
    logic        rw1, halt1;
    logic [31:0] pc2, pc2_p4;
    logic [3:0]  ret2;
    logic        rw2, halt2;

    int n_tests = 0;
    int n_fail  = 0;

    vec_t tv1[$];
    vec_t tv2[$];

    pc_fetch_unit dut1 (
        .CLK(clk), .Reset(rst_n), .PCWre(PCWre), .PCSrc(PCSrc), .zero(zero),
        .immediate(immediate), .jump_addr(jump_addr), .op(op), .resume(resume),
        .pc(pc1), .pc_plus4(pc1_p4), .InsMemRW(rw1), .halted(halt1), .retired(ret1)
    );

    pc_fetch_unit #(.RESET_PC(32'hEFFF_FFFC), .CNT_W(4)) dut2 (
        .CLK(clk), .Reset(rst2_n), .PCWre(PCWre), .PCSrc(PCSrc), .zero(zero),
        .immediate(immediate), .jump_addr(jump_addr), .op(op), .resume(resume),
        .pc(pc2), .pc_plus4(pc2_p4), .InsMemRW(rw2), .halted(halt2), .retired(ret2)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_tests++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got %h, expected %h", name, act, exp);
        end
    endtask

    function automatic vec_t mk(input logic pcwre, input logic [1:0] pcsrc, input logic z,
                                input logic [15:0] imm, input logic [25:0] ja,
                                input logic [5:0] o, input logic res,
                                input logic [31:0] epc, input logic [31:0] eret,
                                input logic eh, input logic erw);
        vec_t v;
        v.pcwre = pcwre; v.pcsrc = pcsrc; v.zero = z; v.imm = imm; v.jaddr = ja;
        v.op = o; v.resume = res; v.e_pc = epc; v.e_ret = eret; v.e_halt = eh; v.e_rw = erw;
        return v;
    endfunction

    // Drive one vector, let one rising edge pass, then compare after it.
    task automatic run_vec(input vec_t v, input bit sel2, input int idx);
        PCWre = v.pcwre; PCSrc = v.pcsrc; zero = v.zero; immediate = v.imm;
        jump_addr = v.jaddr; op = v.op; resume = v.resume;
        @(posedge clk);
        #1;
        if (!sel2) begin
            check($sformatf("v1[%0d] pc", idx), pc1, v.e_pc);
            check($sformatf("v1[%0d] pc_plus4", idx), pc1_p4, v.e_pc + 32'd4);
            check($sformatf("v1[%0d] retired", idx), ret1, v.e_ret);
            check($sformatf("v1[%0d] halted", idx), {31'b0, halt1}, {31'b0, v.e_halt});
            check($sformatf("v1[%0d] InsMemRW", idx), {31'b0, rw1}, {31'b0, v.e_rw});
        end else begin
            check($sformatf("v2[%0d] pc", idx), pc2, v.e_pc);
            check($sformatf("v2[%0d] pc_plus4", idx), pc2_p4, v.e_pc + 32'd4);
            check($sformatf("v2[%0d] retired", idx), {28'b0, ret2}, v.e_ret);
            check($sformatf("v2[%0d] halted", idx), {31'b0, halt2}, {31'b0, v.e_halt});
            check($sformatf("v2[%0d] InsMemRW", idx), {31'b0, rw2}, {31'b0, v.e_rw});
        end
    endtask

    initial begin
        rst_n = 1'b0; rst2_n = 1'b0;
        PCWre = 1'b0; PCSrc = 2'b00; zero = 1'b0; immediate = '0;
        jump_addr = '0; op = '0; resume = 1'b0;

        // pcwre pcsrc zero imm jaddr op resume | pc ret halted rw
        tv1.push_back(mk(1, 2'b00, 0, 16'h0, 26'h0, 6'h00, 0, 32'h00, 0, 0, 1)); // BOOT holds pc
        tv1.push_back(mk(1, 2'b00, 0, 16'h0, 26'h0, 6'h00, 0, 32'h04, 1, 0, 1));
        tv1.push_back(mk(1, 2'b00, 0, 16'h0, 26'h0, 6'h00, 0, 32'h08, 2, 0, 1));
        tv1.push_back(mk(1, 2'b00, 0, 16'h0, 26'h0, 6'h00, 0, 32'h0C, 3, 0, 1));
        tv1.push_back(mk(1, 2'b00, 0, 16'h0, 26'h0, 6'h00, 0, 32'h10, 4, 0, 1));
        tv1.push_back(mk(1, 2'b00, 0, 16'h0, 26'h0, 6'h00, 0, 32'h14, 5, 0, 1));
        tv1.push_back(mk(0, 2'b00, 0, 16'h0, 26'h0, 6'h00, 0, 32'h14, 5, 0, 1)); // stall
        tv1.push_back(mk(0, 2'b10, 0, 16'h0, 26'h123, 6'h00, 0, 32'h14, 5, 0, 1));
        tv1.push_back(mk(1, 2'b00, 0, 16'h0, 26'h0, 6'h00, 0, 32'h18, 6, 0, 1));
        tv1.push_back(mk(1, 2'b00, 0, 16'h0, 26'h0, 6'h00, 0, 32'h1C, 7, 0, 1));
        tv1.push_back(mk(1, 2'b01, 0, 16'h0004, 26'h0, 6'h00, 0, 32'h20, 8, 0, 1)); // not taken
        tv1.push_back(mk(1, 2'b00, 0, 16'h0, 26'h0, 6'h00, 0, 32'h24, 9, 0, 1));
        tv1.push_back(mk(1, 2'b00, 0, 16'h0, 26'h0, 6'h00, 0, 32'h28, 10, 0, 1));
        tv1.push_back(mk(1, 2'b00, 0, 16'h0, 26'h0, 6'h00, 0, 32'h2C, 11, 0, 1));
        tv1.push_back(mk(1, 2'b01, 1, 16'hFFFB, 26'h0, 6'h00, 0, 32'h1C, 12, 0, 1)); // back branch
        tv1.push_back(mk(1, 2'b01, 1, 16'h0004, 26'h0, 6'h00, 0, 32'h30, 13, 0, 1)); // fwd branch
        tv1.push_back(mk(1, 2'b10, 0, 16'h0, 26'h10, 6'h00, 0, 32'h40, 14, 0, 1));   // jump
        tv1.push_back(mk(1, 2'b10, 0, 16'h0, 26'h0C, 6'h00, 0, 32'h30, 15, 0, 1));
        tv1.push_back(mk(1, 2'b11, 0, 16'h0, 26'h0, 6'h00, 0, 32'h30, 16, 0, 1));    // hold src
        tv1.push_back(mk(1, 2'b10, 0, 16'h0, 26'h55, 6'h3F, 0, 32'h30, 16, 1, 0));   // halt wins
        tv1.push_back(mk(0, 2'b01, 1, 16'h4, 26'h0, 6'h00, 0, 32'h30, 16, 1, 0));
        tv1.push_back(mk(1, 2'b00, 0, 16'h0, 26'h0, 6'h3F, 0, 32'h30, 16, 1, 0));
        tv1.push_back(mk(1, 2'b11, 0, 16'h0, 26'h0, 6'h00, 0, 32'h30, 16, 1, 0));
        tv1.push_back(mk(0, 2'b10, 0, 16'h0, 26'h7, 6'h00, 0, 32'h30, 16, 1, 0));
        tv1.push_back(mk(1, 2'b00, 0, 16'h0, 26'h0, 6'h3F, 1, 32'h34, 16, 0, 1));    // resume, op still halt
        tv1.push_back(mk(1, 2'b00, 0, 16'h0, 26'h0, 6'h3F, 0, 32'h34, 16, 1, 0));    // re-halts in RUN
        tv1.push_back(mk(1, 2'b00, 0, 16'h0, 26'h0, 6'h00, 1, 32'h38, 16, 0, 1));
        tv1.push_back(mk(0, 2'b00, 0, 16'h0, 26'h0, 6'h00, 1, 32'h38, 16, 0, 1));    // resume ignored in RUN
        tv1.push_back(mk(1, 2'b00, 0, 16'h0, 26'h0, 6'h00, 0, 32'h3C, 17, 0, 1));

        tv2.push_back(mk(1, 2'b00, 0, 16'h0, 26'h0, 6'h00, 0, 32'hEFFF_FFFC, 0, 0, 1)); // BOOT
        tv2.push_back(mk(1, 2'b00, 0, 16'h0, 26'h0, 6'h00, 0, 32'hF000_0000, 1, 0, 1));
        tv2.push_back(mk(1, 2'b10, 0, 16'h0, 26'h10, 6'h00, 0, 32'hF000_0040, 2, 0, 1));
        tv2.push_back(mk(1, 2'b10, 0, 16'h0, 26'h3FF_FFFF, 6'h00, 0, 32'hFFFF_FFFC, 3, 0, 1));
        tv2.push_back(mk(1, 2'b00, 0, 16'h0, 26'h0, 6'h00, 0, 32'h0000_0000, 4, 0, 1)); // wrap
        for (int k = 1; k <= 13; k++) begin
            tv2.push_back(mk(1, 2'b00, 0, 16'h0, 26'h0, 6'h00, 0, 32'(4 * k),
                             32'((4 + k > 15) ? 15 : 4 + k), 0, 1));
        end

        // Reset held for 3 cycles, then released on a falling edge.
        repeat (3) @(posedge clk);
        @(negedge clk);
        rst_n = 1'b1;
        #1;
        check("boot pc", pc1, 32'h0);
        check("boot InsMemRW", {31'b0, rw1}, 32'h0);
        check("boot halted", {31'b0, halt1}, 32'h0);
        check("boot retired", ret1, 32'h0);

        for (int i = 0; i < tv1.size(); i++) run_vec(tv1[i], 1'b0, i);

        // Mid-run async reset during a stall at pc = 0x14.
        @(negedge clk);
        rst_n = 1'b0;
        @(negedge clk);
        rst_n = 1'b1;
        for (int i = 0; i < 6; i++) run_vec(tv1[i], 1'b0, 100 + i);
        PCWre = 1'b0;
        #2;
        rst_n = 1'b0;
        #1;
        check("async reset pc", pc1, 32'h0);
        check("async reset retired", ret1, 32'h0);
        check("async reset InsMemRW", {31'b0, rw1}, 32'h0);
        check("async reset halted", {31'b0, halt1}, 32'h0);
        @(posedge clk);
        #1;
        check("reset held pc", pc1, 32'h0);

        // High-address / saturating instance.
        @(negedge clk);
        rst2_n = 1'b1;
        #1;
        check("dut2 boot pc", pc2, 32'hEFFF_FFFC);
        check("dut2 boot InsMemRW", {31'b0, rw2}, 32'h0);
        for (int i = 0; i < tv2.size(); i++) run_vec(tv2[i], 1'b1, i);

        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

endmodule
